// File: rtl/cpu16_pkg.sv
// Shared constants and types for the cpu16 front end: word width, fetch
// defaults, fetch FSM encoding and the instruction queue entry layout.
package cpu16_pkg;

    localparam int          WORD_W         = 16;
    localparam int          FETCH_DEPTH    = 4;
    localparam logic [15:0] FETCH_RESET_PC = 16'h0000;

    // Fetch FSM encoding.
    localparam logic [1:0] FETCH_IDLE = 2'd0;  // no ROM request outstanding
    localparam logic [1:0] FETCH_WAIT = 2'd1;  // one request outstanding, response wanted
    localparam logic [1:0] FETCH_DROP = 2'd2;  // one request outstanding, response discarded

    typedef logic [WORD_W-1:0] word_t;

    // Queue entry: the address a word came from, and the word itself.
    typedef struct packed {
        word_t pc;
        word_t word;
    } fetch_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Synchronous instruction FIFO holding {pc, word} entries between the ROM
// and decode. DEPTH must be a power of two so pointers wrap naturally.
module instr_queue
    import cpu16_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_MAX);
    assign empty     = (count == '0);
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Entry storage write port.
    // NOTE: storage has no reset; count and pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one ROM request at a time, tags each
// returned word with its address, buffers it in instr_queue and hands it to
// decode. A redirect flushes the queue and discards any in-flight response.
module fetch_unit
    import cpu16_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH,
    parameter logic [15:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        rom_req,
    output logic [15:0] rom_addr,
    input  logic        rom_valid,
    input  logic [15:0] rom_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    word_t            fetch_pc;
    word_t            req_pc;
    logic             issue;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] q_count;
    logic             q_full;
    logic             q_empty;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    // Redirect wins over everything: no issue, no push, no pop in that cycle.
    assign issue      = (state == FETCH_IDLE) && !redirect && (q_count < DEPTH_C);
    assign push       = (state == FETCH_WAIT) && rom_valid && !redirect && !q_full;
    assign pop        = instr_valid && instr_ready && !redirect;
    assign push_entry = '{pc: req_pc, word: rom_data};

    // The request address register doubles as the tag for the returning word.
    assign rom_addr    = req_pc;
    assign instr_valid = !q_empty;
    assign instr       = instr_valid ? head.word : '0;
    assign instr_pc    = instr_valid ? head.pc   : '0;

    // Next state: a pending response is either accepted or, after a redirect, dropped.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_IDLE: if (issue) state_nxt = FETCH_WAIT;
            FETCH_WAIT: begin
                if (rom_valid)     state_nxt = FETCH_IDLE;
                else if (redirect) state_nxt = FETCH_DROP;
            end
            FETCH_DROP: if (rom_valid) state_nxt = FETCH_IDLE;
            default:    state_nxt = FETCH_IDLE;
        endcase
    end

    // FSM, fetch PC, request pulse and request tag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            rom_req  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rom_req <= issue;
            if (redirect)   fetch_pc <= redirect_pc;
            else if (issue) fetch_pc <= fetch_pc + 16'd1;
            if (issue) req_pc <= fetch_pc;
        end
    end

    instr_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (reset),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .flush    (redirect),
        .head_data(head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a ROM responder with random latency,
// random decode back-pressure and redirects, checked every cycle against a
// transaction-level model (queue of fetched addresses plus request bookkeeping).
module tb_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'hFFFF;

    logic        clk         = 1'b0;
    logic        reset       = 1'b0;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_valid   = 1'b0;
    logic [15:0] rom_data    = '0;
    logic        redirect    = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;

    fetch_unit #(
        .DEPTH   (DEPTH),
        .RESET_PC(RST_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_valid  (rom_valid),
        .rom_data   (rom_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ROM contents: a bijective scramble of the address.
    function automatic logic [15:0] rom_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Reference model: addresses whose words decode should see, in order,
    // plus the single outstanding request and whether a redirect killed it.
    logic [15:0] mq[$];
    bit          m_out;
    bit          m_live;
    bit          m_req;
    logic [15:0] m_pc_out;
    logic [15:0] m_fetch;

    // ROM responder state and stimulus knobs.
    bit          rom_pend      = 0;
    logic [15:0] rom_pend_addr = '0;
    int          rom_wait      = 0;
    int          rom_lat       = 1;
    int          lat_lo        = 1;
    int          lat_hi        = 1;
    int          p_ready       = 0;
    int          p_redir       = 0;
    int          p_spur        = 0;
    int          req_seen      = 0;
    bit          saw_req       = 0;
    logic [15:0] last_req_addr = '0;
    logic        last_valid    = 1'b0;
    logic [15:0] last_instr    = '0;
    logic [15:0] last_instr_pc = '0;

    function automatic void model_reset();
        mq.delete();
        m_out   = 0;
        m_live  = 0;
        m_req   = 0;
        m_fetch = RST_PC;
    endfunction

    // Advance the model across one rising edge given the inputs seen before it.
    function automatic void model_edge(input bit rst_s, input bit rv, input bit rr,
                                       input bit rdy, input logic [15:0] rpc);
        int n;
        bit do_issue;
        if (!rst_s) begin
            model_reset();
            return;
        end
        n        = mq.size();
        do_issue = !m_out && !rr && (n < DEPTH);
        if (rr) begin
            mq.delete();
            m_live = 0;
        end else begin
            if (n != 0 && rdy) void'(mq.pop_front());
            if (rv && m_out && m_live) mq.push_back(m_pc_out);
        end
        if (rv && m_out) m_out = 0;
        if (rr) m_fetch = rpc;
        m_req = do_issue;
        if (do_issue) begin
            m_out    = 1;
            m_live   = 1;
            m_pc_out = m_fetch;
            m_fetch  = m_fetch + 16'd1;
        end
    endfunction

    // Pick this cycle's inputs: ROM response, spurious strobes, back-pressure, redirects.
    task automatic drive_next();
        rom_valid = 1'b0;
        rom_data  = 16'($urandom);
        if (rom_pend) begin
            rom_wait++;
            if (rom_wait >= rom_lat) begin
                rom_valid = 1'b1;
                rom_data  = rom_word(rom_pend_addr);
                rom_pend  = 0;
            end
        end else if (!rom_req && int'($urandom_range(99, 0)) < p_spur) begin
            rom_valid = 1'b1;
        end
        instr_ready = int'($urandom_range(99, 0)) < p_ready;
        redirect    = int'($urandom_range(99, 0)) < p_redir;
        redirect_pc = ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom);
    endtask

    // One clock: compare on the falling edge, update the model on the rising
    // edge, then drive the next inputs 1 time unit later.
    task automatic cycle();
        bit          s_rst, s_rv, s_rr, s_rdy;
        logic [15:0] s_rpc;
        @(negedge clk);
        check("rom_req", rom_req, m_req);
        if (m_req) check("rom_addr", rom_addr, m_pc_out);
        check("instr_valid", instr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("instr_pc", instr_pc, mq[0]);
            check("instr", instr, rom_word(mq[0]));
        end
        saw_req       = 0;
        last_valid    = instr_valid;
        last_instr    = instr;
        last_instr_pc = instr_pc;
        if (reset && rom_req) begin
            check("one_outstanding", rom_pend, 0);
            rom_pend      = 1;
            rom_pend_addr = rom_addr;
            rom_wait      = 0;
            rom_lat       = int'($urandom_range(lat_hi, lat_lo));
            req_seen++;
            saw_req       = 1;
            last_req_addr = rom_addr;
        end
        s_rst = reset;
        s_rv  = rom_valid;
        s_rr  = redirect;
        s_rdy = instr_ready;
        s_rpc = redirect_pc;
        @(posedge clk);
        model_edge(s_rst, s_rv, s_rr, s_rdy, s_rpc);
        #1;
        drive_next();
    endtask

    task automatic wait_req(input int budget, output bit found);
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            cycle();
            found = saw_req;
        end
    endtask

    initial begin
        bit found;
        int base;

        // Reset state.
        model_reset();
        repeat (3) cycle();
        check("rst_rom_req", rom_req, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 16'h0000);
        check("rst_instr_pc", instr_pc, 16'h0000);

        // Release with decode stalled: exactly DEPTH requests, then the fetcher waits.
        reset   = 1'b1;
        base    = req_seen;
        lat_lo  = 1;
        lat_hi  = 2;
        p_ready = 0;
        repeat (40) cycle();
        check("full_req_count", req_seen - base, DEPTH);
        check("full_valid", instr_valid, 1);
        check("full_head_pc", instr_pc, RST_PC);

        // Release decode with a 1-cycle ROM: entries drain in order, fetching wraps and resumes.
        lat_hi  = 1;
        p_ready = 100;
        repeat (40) cycle();
        check("resume_fetch", (req_seen - base) > 8, 1);

        // Redirect while a request is outstanding; its late response must be dropped.
        lat_lo = 3;
        lat_hi = 3;
        wait_req(20, found);
        check("redir_wait_found", found, 1);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        cycle();
        wait_req(20, found);
        check("redir_next_found", found, 1);
        check("redir_next_addr", last_req_addr, 16'h0040);

        // Redirect coinciding with a ROM response and a pop.
        lat_lo  = 1;
        lat_hi  = 1;
        p_ready = 0;
        found   = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            found = saw_req && (mq.size() >= 2);
        end
        check("coinc_setup_found", found, 1);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h1234;
        cycle();
        cycle();
        check("coinc_flushed", last_valid, 0);
        wait_req(20, found);
        check("coinc_next_found", found, 1);
        check("coinc_next_addr", last_req_addr, 16'h1234);

        // Reset in the middle of a request; a stale response right after release is ignored.
        lat_lo  = 6;
        lat_hi  = 6;
        p_ready = 50;
        wait_req(20, found);
        check("midrst_found", found, 1);
        reset     = 1'b0;
        model_reset();
        rom_pend  = 0;
        rom_valid = 1'b0;
        redirect  = 1'b0;
        cycle();
        check("midrst_valid", instr_valid, 0);
        check("midrst_instr", instr, 16'h0000);
        check("midrst_instr_pc", instr_pc, 16'h0000);
        reset       = 1'b1;
        rom_valid   = 1'b1;
        rom_data    = 16'hDEAD;
        redirect    = 1'b0;
        instr_ready = 1'b1;
        p_ready     = 100;
        lat_lo      = 1;
        lat_hi      = 1;
        cycle();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = last_valid;
        end
        check("midrst_first_found", found, 1);
        check("midrst_first_pc", last_instr_pc, RST_PC);
        check("midrst_first_word", last_instr, rom_word(RST_PC));

        // Random traffic: variable latency, back-pressure, redirects, spurious strobes.
        lat_lo  = 1;
        lat_hi  = 4;
        p_ready = 60;
        p_redir = 6;
        p_spur  = 10;
        repeat (3000) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
